// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, FSM encodings,
// instruction field bit positions and the branch offset helper.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JT_HI    = 25;
    localparam int JT_LO    = 0;

    // Word offset scaled to bytes and sign-extended to 32 bits.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_logic.sv
// Combinational next-PC selection: jump beats taken branch, otherwise sequential.
// All arithmetic is 32-bit and wraps naturally.
module next_pc_logic
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        jump_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] jtarget_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc4;

    assign pc4 = pc_i + 32'd4;

    always_comb begin
        next_pc_o = pc4;
        if (jump_i) begin
            next_pc_o = {pc4[31:28], jtarget_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_o = pc4 + branch_offset(imm_i);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch front end: PC register, request/ack handshake to instruction memory,
// instruction register with field slicing, and valid/ready hand-off to decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jtarget
);

    // Low bits forced to zero so a misaligned parameter can never reach the PC.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ir_q;
    logic         imem_req_q;
    logic         if_valid_q;
    logic [31:0]  next_pc_d;

    next_pc_logic u_next_pc (
        .pc_i      (pc_q),
        .jump_i    (jump),
        .branch_i  (branch),
        .zero_i    (zero),
        .imm_i     (ir_q[IMM_HI:IMM_LO]),
        .jtarget_i (ir_q[JT_HI:JT_LO]),
        .next_pc_o (next_pc_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_INIT;
            ir_q       <= 32'h0000_0000;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_REQ;
                    imem_req_q <= 1'b1;
                    if_valid_q <= 1'b0;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        state_q    <= ST_VALID;
                        imem_req_q <= 1'b0;
                        if_valid_q <= 1'b1;
                    end
                end
                ST_VALID: begin
                    // Control inputs only matter on the hand-off cycle.
                    if (id_ready) begin
                        pc_q       <= {next_pc_d[31:2], 2'b00};
                        state_q    <= ST_REQ;
                        imem_req_q <= 1'b1;
                        if_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign pc_out    = pc_q;

    assign opcode  = ir_q[OP_HI:OP_LO];
    assign rs      = ir_q[RS_HI:RS_LO];
    assign rt      = ir_q[RT_HI:RT_LO];
    assign rd      = ir_q[RD_HI:RD_LO];
    assign funct   = ir_q[FUNCT_HI:FUNCT_LO];
    assign imm     = ir_q[IMM_HI:IMM_LO];
    assign jtarget = ir_q[JT_HI:JT_LO];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: walks a hand-planned PC trail covering
// sequential fetch, branches, jumps, backpressure, wrap and asynchronous reset.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        id_ready;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] pc_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jtarget;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .id_ready   (id_ready),
        .jump       (jump),
        .branch     (branch),
        .zero       (zero),
        .pc_out     (pc_out),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .funct      (funct),
        .imm        (imm),
        .jtarget    (jtarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for a request, checks its address, acks after ack_delay cycles and
    // checks that the word lands in IR with pc_out pointing at it.
    task automatic do_fetch(input string name, input logic [31:0] exp_addr,
                            input logic [31:0] word, input int ack_delay);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_req_timeout: imem_req=%b required 1", name, imem_req);
        end
        n_checks++;
        if (imem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL %s_addr: got %h required %h", name, imem_addr, exp_addr);
        end
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_req_hold: req=%b addr=%h valid=%b required 1/%h/0",
                         name, imem_req, imem_addr, if_valid, exp_addr);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_valid: valid=%b req=%b required 1/0", name, if_valid, imem_req);
        end
        n_checks++;
        if (pc_out !== exp_addr) begin
            n_fail++;
            $display("FAIL %s_pc_out: got %h required %h", name, pc_out, exp_addr);
        end
        n_checks++;
        if ({opcode, jtarget} !== word) begin
            n_fail++;
            $display("FAIL %s_ir: got %h required %h", name, {opcode, jtarget}, word);
        end
    endtask

    task automatic retire(input string name, input logic j, input logic b, input logic z);
        jump     = j;
        branch   = b;
        zero     = z;
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        jump     = 1'b0;
        branch   = 1'b0;
        zero     = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_retire: valid=%b req=%b required 0/1", name, if_valid, imem_req);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        id_ready   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: req=%b valid=%b required 0/0", imem_req, if_valid);
        end
        n_checks++;
        if (imem_addr !== 32'h0 || pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc: addr=%h pc_out=%h required 0", imem_addr, pc_out);
        end
        n_checks++;
        if ({opcode, rs, rt, rd, funct, imm, jtarget} !== 69'h0) begin
            n_fail++;
            $display("FAIL reset_fields: opcode=%h imm=%h jtarget=%h required 0",
                     opcode, imm, jtarget);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_fetch("seq0", 32'h0000_0000, 32'h012A_4020, 1);
        n_checks++;
        if (opcode !== 6'h00 || rs !== 5'd9 || rt !== 5'd10 || rd !== 5'd8 ||
            funct !== 6'h20 || imm !== 16'h4020 || jtarget !== 26'h12A_4020) begin
            n_fail++;
            $display("FAIL seq0_fields: op=%h rs=%0d rt=%0d rd=%0d fn=%h imm=%h jt=%h required 00/9/10/8/20/4020/12a4020",
                     opcode, rs, rt, rd, funct, imm, jtarget);
        end
        retire("seq0", 1'b0, 1'b0, 1'b0);
        do_fetch("seq4", 32'h0000_0004, 32'h0000_0000, 0);
        retire("seq4", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        do_fetch("beq_nt", 32'h0000_0008, 32'h1109_0003, 1);
        n_checks++;
        if (opcode !== 6'h04 || imm !== 16'h0003 || rs !== 5'd8 || rt !== 5'd9) begin
            n_fail++;
            $display("FAIL beq_fields: op=%h imm=%h rs=%0d rt=%0d required 04/0003/8/9",
                     opcode, imm, rs, rt);
        end
        retire("beq_nt", 1'b0, 1'b1, 1'b0);
        do_fetch("jmp_back", 32'h0000_000C, 32'h0800_0002, 0);
        retire("jmp_back", 1'b1, 1'b0, 1'b0);
        do_fetch("beq_t", 32'h0000_0008, 32'h1109_0003, 2);
        retire("beq_t", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_jump_priority();
        do_fetch("jpri", 32'h0000_0018, 32'h0800_0010, 1);
        n_checks++;
        if (jtarget !== 26'h000_0010 || opcode !== 6'h02) begin
            n_fail++;
            $display("FAIL jpri_fields: jt=%h op=%h required 0000010/02", jtarget, opcode);
        end
        retire("jpri", 1'b1, 1'b1, 1'b1);
        do_fetch("j40", 32'h0000_0040, 32'h0800_0008, 1);
        retire("j40", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_negative_and_wrap();
        do_fetch("neg4", 32'h0000_0020, 32'h1109_FFFF, 1);
        retire("neg4", 1'b0, 1'b1, 1'b1);
        do_fetch("neg40", 32'h0000_0020, 32'h1109_FFF6, 0);
        retire("neg40", 1'b0, 1'b1, 1'b1);
        do_fetch("top", 32'hFFFF_FFFC, 32'h0000_0000, 1);
        retire("top", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_fetch("wrap0", 32'h0000_0000, 32'h8D28_0004, 1);
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h1234_5678;
            @(negedge clk);
            n_checks++;
            if (if_valid !== 1'b1 || imem_req !== 1'b0 || opcode !== 6'h23 ||
                imm !== 16'h0004 || pc_out !== 32'h0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b req=%b op=%h imm=%h pc=%h required 1/0/23/0004/0",
                         i, if_valid, imem_req, opcode, imm, pc_out);
            end
        end
        imem_ack = 1'b0;
        retire("bp", 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (imem_addr !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL bp_release_addr: got %h required 00000004", imem_addr);
        end
    endtask

    task automatic test_async_reset_mid_req();
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h0 || opcode !== 6'h00) begin
            n_fail++;
            $display("FAIL async_rst: req=%b valid=%b addr=%h op=%h required 0/0/0/00",
                     imem_req, if_valid, imem_addr, opcode);
        end
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_hold: req=%b valid=%b required 0/0", imem_req, if_valid);
        end
        imem_ack = 1'b0;
        rst      = 1'b1;
        do_fetch("restart", 32'h0000_0000, 32'h2008_0005, 2);
        retire("restart", 1'b0, 1'b0, 1'b0);
        do_fetch("restart4", 32'h0000_0004, 32'h0000_0000, 0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_negative_and_wrap();
        test_backpressure();
        test_async_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
